// File: rtl/pipe_reg_skid_if.sv
// Valid/ready stage-to-stage bus carrying a payload bundle and a control bundle.
// The producer uses master and the consumer uses slave.
interface pipe_reg_skid_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_reg_skid.sv
// Flow-controlled pipeline register with optional skid entry; 1-cycle latency, 1 transfer/cycle.
// Backpressure: SKID=1 gives a registered in_ready (no out_ready path); SKID=0 passes out_ready through.
module pipe_reg_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   flush,
  pipe_reg_skid_if.slave         in_bus,
  pipe_reg_skid_if.master        out_bus,
  output logic [1:0]             occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic m_valid;
  logic s_valid;
  logic in_ready;
  logic accept;
  logic drain;

  assign m_valid = (state_q != ST_EMPTY);
  assign s_valid = (state_q == ST_FULL);

  // Flush squashes both directions so neither an offered input nor the held head moves.
  assign accept = in_bus.valid & in_ready & ~flush;
  assign drain  = m_valid & out_bus.ready & ~flush;

  always_ff @(posedge CLK) begin
    state_q  <= state_d;
    active_q <= active_d;
    m_data_q <= m_data_d;
    m_ctrl_q <= m_ctrl_d;
    s_data_q <= s_data_d;
    s_ctrl_q <= s_ctrl_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !drain) begin
          state_d = (SKID != 0) ? ST_FULL : ST_ONE;
        end else if (!accept && drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL:  if (drain) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (reset || flush) state_d = ST_EMPTY;
  end

  always_comb begin
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    active_d = ~reset;
    if (drain && s_valid) begin
      m_data_d = s_data_q;
      m_ctrl_d = s_ctrl_q;
    end else if (accept && (!m_valid || drain)) begin
      m_data_d = in_bus.data;
      m_ctrl_d = in_bus.ctrl;
    end else if (accept && (SKID != 0)) begin
      s_data_d = in_bus.data;
      s_ctrl_d = in_bus.ctrl;
    end
    if (reset) begin
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end
  end

  always_comb begin
    if (SKID != 0) begin
      in_ready = active_q & ~s_valid;
    end else begin
      in_ready = active_q & (~m_valid | out_bus.ready);
    end
    in_bus.ready  = in_ready;
    out_bus.valid = m_valid;
    out_bus.data  = m_data_q;
    // Bubbles must never carry a write enable or write address downstream.
    out_bus.ctrl  = m_valid ? m_ctrl_q : '0;
    occupancy     = state_q;
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: one SKID=1 and one SKID=0 instance, exercised in turn against a
// scoreboard queue that also predicts out_valid, occupancy and in_ready every cycle.
module tb_pipe_reg_skid;
  localparam int DW = 64;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic          sel;
  logic [1:0]    occ1;
  logic [1:0]    occ0;

  always #5 CLK = ~CLK;

  pipe_reg_skid_if #(.DATA_W(DW), .CTRL_W(CW)) in1 ();
  pipe_reg_skid_if #(.DATA_W(DW), .CTRL_W(CW)) out1 ();
  pipe_reg_skid_if #(.DATA_W(DW), .CTRL_W(CW)) in0 ();
  pipe_reg_skid_if #(.DATA_W(DW), .CTRL_W(CW)) out0 ();

  assign in1.valid  = in_valid & sel;
  assign in1.data   = in_data;
  assign in1.ctrl   = in_ctrl;
  assign out1.ready = out_ready;
  assign in0.valid  = in_valid & ~sel;
  assign in0.data   = in_data;
  assign in0.ctrl   = in_ctrl;
  assign out0.ready = out_ready;

  pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_bus(in1), .out_bus(out1), .occupancy(occ1)
  );

  pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_bus(in0), .out_bus(out0), .occupancy(occ0)
  );

  logic          obs_rdy;
  logic          obs_vld;
  logic [DW-1:0] obs_dat;
  logic [CW-1:0] obs_ctl;
  logic [1:0]    obs_occ;

  assign obs_rdy = sel ? in1.ready  : in0.ready;
  assign obs_vld = sel ? out1.valid : out0.valid;
  assign obs_dat = sel ? out1.data  : out0.data;
  assign obs_ctl = sel ? out1.ctrl  : out0.ctrl;
  assign obs_occ = sel ? occ1       : occ0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (skid=%0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t sb[$];
  bit   mon_en = 1'b0;
  bit   alive  = 1'b0;

  always @(posedge CLK) alive <= !reset;

  always @(negedge CLK) begin
    ent_t e;
    if (mon_en) begin
      if (!alive) begin
        check("rst_vld", obs_vld, 0);
        check("rst_ctrl", obs_ctl, 0);
        check("rst_dat", obs_dat, 0);
        check("rst_occ", obs_occ, 0);
        check("rst_rdy", obs_rdy, 0);
      end else begin
        check("vld", obs_vld, sb.size() != 0);
        check("occ", obs_occ, sb.size());
        if (!obs_vld) check("mask", obs_ctl, 0);
        check("rdy", obs_rdy, sel ? (sb.size() < 2) : (sb.size() == 0 || out_ready));
      end
      if (reset || flush) begin
        sb.delete();
      end else begin
        if (obs_vld && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check("dat", obs_dat, e.d);
          check("ctl", obs_ctl, e.c);
        end
        if (in_valid && obs_rdy) sb.push_back({in_data, in_ctrl});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input logic [7:0] c);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    in_ctrl  = c;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      done = obs_rdy && !flush && !reset;
      tick();
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !empty; i++) begin
      if (sb.size() == 0) empty = 1'b1;
      else tick();
    end
    if (!empty) check("drain_timeout", 0, 1);
    tick();
  endtask

  task automatic stream();
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) send(64'(v), 8'(v) ^ 8'h5A);
    drain();
  endtask

  task automatic busywait();
    out_ready = 1'b0;
    fork
      begin
        send(64'hA, 8'h1A);
        send(64'hB, 8'h1B);
        send(64'hC, 8'h1C);
      end
      begin
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic bubble();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = 8'hFF;
    repeat (3) tick();
    send(64'h77, 8'hFF);
    repeat (2) tick();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    in_ctrl   = 8'hAD;
    out_ready = 1'b1;
    sel       = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (3) tick();
    check("rst_rdy_skid0", in0.ready, 0);
    check("rst_occ_skid0", occ0, 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (3) tick();

    stream();
    busywait();

    // Flush while full with a stalled input offered.
    out_ready = 1'b0;
    send(64'h1, 8'h01);
    send(64'h2, 8'h02);
    in_valid = 1'b1;
    in_data  = 64'h3;
    in_ctrl  = 8'h03;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_full_occ", obs_occ, 0);
    check("flush_full_vld", obs_vld, 0);

    // Flush while in_ready=1: the offered input must still be dropped.
    send(64'h4, 8'h04);
    in_valid = 1'b1;
    in_data  = 64'h5;
    in_ctrl  = 8'h05;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_one_occ", obs_occ, 0);
    out_ready = 1'b1;
    send(64'h6, 8'h06);
    check("post_flush_latency", obs_vld, 1);
    drain();

    bubble();

    // Reset with two entries held.
    out_ready = 1'b0;
    send(64'h8, 8'h08);
    send(64'h9, 8'h09);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (2) tick();

    sel = 1'b0;
    tick();
    stream();
    busywait();

    // Full single-entry register: in_ready tracks out_ready between edges.
    out_ready = 1'b0;
    send(64'h10, 8'h10);
    #1;
    check("comb_rdy_lo", obs_rdy, 0);
    out_ready = 1'b1;
    #1;
    check("comb_rdy_hi", obs_rdy, 1);
    drain();

    bubble();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
